// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_unit                                                |
// | Description : Iterative RV32M multiply/divide engine with valid/ready    |
// |               handshakes on request and result sides. Radix-2 shift-add  |
// |               multiply, restoring divide, full RISC-V divide-by-zero and |
// |               signed-overflow results.                                   |
// | Option      : MULDIV_FAST_MUL_EN - single-cycle multiply at accept.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   SYS_clk       in   clock, rising edge                                  |
// |   SYS_reset     in   synchronous active-high reset                       |
// |   MD_valid_in   in   request valid                                       |
// |   MD_ready_out  out  request accepted when high (IDLE only)              |
// |   MD_funct3     in   RV32M operation select                              |
// |   MD_rs1_data   in   operand A                                           |
// |   MD_rs2_data   in   operand B                                           |
// |   MD_rd_in      in   destination register tag                            |
// |   MD_valid_out  out  result valid (DONE)                                 |
// |   MD_ready_in   in   consumer accepts result                             |
// |   MD_result     out  result                                              |
// |   MD_rd_out     out  tag captured with the request                       |
// |   MD_busy       out  operation in flight (CALC or DONE)                  |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            MD_valid_in,
  output logic            MD_ready_out,
  input  logic [2:0]      MD_funct3,
  input  logic [XLEN-1:0] MD_rs1_data,
  input  logic [XLEN-1:0] MD_rs2_data,
  input  logic [4:0]      MD_rd_in,
  output logic            MD_valid_out,
  input  logic            MD_ready_in,
  output logic [XLEN-1:0] MD_result,
  output logic [4:0]      MD_rd_out,
  output logic            MD_busy
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        op;
  logic              neg_res;   // product or quotient sign
  logic              neg_rem;   // remainder follows the dividend sign
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   rem;
  // Multiply: {partial sum, remaining multiplier bits}.
  // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  count;

  // Accept-side decode
  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   special_result;

  always_comb begin
    a_signed = (MD_funct3 == 3'b001) || (MD_funct3 == 3'b010) ||
               (MD_funct3 == 3'b100) || (MD_funct3 == 3'b110);
    b_signed = (MD_funct3 == 3'b001) || (MD_funct3 == 3'b100) ||
               (MD_funct3 == 3'b110);
    sa       = a_signed & MD_rs1_data[XLEN-1];
    sb       = b_signed & MD_rs2_data[XLEN-1];
    mag_a_in = sa ? -MD_rs1_data : MD_rs1_data;
    mag_b_in = sb ? -MD_rs2_data : MD_rs2_data;
    div_zero = MD_funct3[2] && (MD_rs2_data == '0);
    // Only the signed divide ops (DIV=100, REM=110) can overflow
    ovf      = MD_funct3[2] && !MD_funct3[0] &&
               (MD_rs1_data == INT_MIN) && (MD_rs2_data == '1);
    special  = div_zero || ovf;
    special_result = '0;
    if (div_zero) begin
      special_result = MD_funct3[1] ? MD_rs1_data : '1;
    end else if (ovf) begin
      special_result = MD_funct3[1] ? '0 : MD_rs1_data;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Low 2*XLEN bits of the product of sign/zero-extended operands are the
  // exact signed/unsigned/mixed product.
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_result;

  always_comb begin
    fast_a      = {{XLEN{sa}}, MD_rs1_data};
    fast_b      = {{XLEN{sb}}, MD_rs2_data};
    fast_prod   = fast_a * fast_b;
    fast_result = (MD_funct3 == 3'b000) ? fast_prod[XLEN-1:0]
                                        : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // One iteration step of each algorithm
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   rem_next, quo_next;
  logic [2*XLEN-1:0] fin_prod;
  logic [XLEN-1:0]   fin_quo, fin_rem, final_result;
  logic              last;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {rem, acc[XLEN-1]};
    div_trial = div_shift - {1'b0, mag_b};
    div_ge    = ~div_trial[XLEN];
    rem_next  = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_next  = {acc[XLEN-2:0], div_ge};
    fin_prod  = neg_res ? -mul_next : mul_next;
    fin_quo   = neg_res ? -quo_next : quo_next;
    fin_rem   = neg_rem ? -rem_next : rem_next;
    case (op)
      3'b000:                final_result = fin_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = fin_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        final_result = fin_quo;
      default:               final_result = fin_rem;
    endcase
    last = (count == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state        <= IDLE;
      MD_ready_out <= 1'b1;
      MD_valid_out <= 1'b0;
      MD_busy      <= 1'b0;
      MD_result    <= '0;
      MD_rd_out    <= '0;
      count        <= '0;
      op           <= '0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      mag_b        <= '0;
      rem          <= '0;
      acc          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MD_valid_in) begin
            op           <= MD_funct3;
            MD_rd_out    <= MD_rd_in;
            neg_res      <= sa ^ sb;
            neg_rem      <= sa;
            mag_b        <= mag_b_in;
            acc          <= {{XLEN{1'b0}}, mag_a_in};
            rem          <= '0;
            count        <= '0;
            MD_ready_out <= 1'b0;
            MD_busy      <= 1'b1;
            if (special) begin
              MD_result    <= special_result;
              MD_valid_out <= 1'b1;
              state        <= DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!MD_funct3[2]) begin
              MD_result    <= fast_result;
              MD_valid_out <= 1'b1;
              state        <= DONE;
`endif
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (op[2]) begin
            acc[XLEN-1:0] <= quo_next;
            rem           <= rem_next;
          end else begin
            acc <= mul_next;
          end
          if (last) begin
            MD_result    <= final_result;
            MD_valid_out <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (MD_ready_in) begin
            MD_valid_out <= 1'b0;
            MD_busy      <= 1'b0;
            MD_ready_out <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          MD_valid_out <= 1'b0;
          MD_busy      <= 1'b0;
          MD_ready_out <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_muldiv_unit                                             |
// | Description : Directed self-checking bench for muldiv_unit (XLEN=32).    |
// |               Honours MULDIV_FAST_MUL_EN for multiply latency.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        MD_valid_in;
  logic        MD_ready_out;
  logic [2:0]  MD_funct3;
  logic [31:0] MD_rs1_data;
  logic [31:0] MD_rs2_data;
  logic [4:0]  MD_rd_in;
  logic        MD_valid_out;
  logic        MD_ready_in;
  logic [31:0] MD_result;
  logic [4:0]  MD_rd_out;
  logic        MD_busy;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .SYS_clk      (SYS_clk),
    .SYS_reset    (SYS_reset),
    .MD_valid_in  (MD_valid_in),
    .MD_ready_out (MD_ready_out),
    .MD_funct3    (MD_funct3),
    .MD_rs1_data  (MD_rs1_data),
    .MD_rs2_data  (MD_rs2_data),
    .MD_rd_in     (MD_rd_in),
    .MD_valid_out (MD_valid_out),
    .MD_ready_in  (MD_ready_in),
    .MD_result    (MD_result),
    .MD_rd_out    (MD_rd_out),
    .MD_busy      (MD_busy)
  );

  always #5 SYS_clk = ~SYS_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present a request, step past the accepting edge, scramble operands.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    MD_valid_in = 1'b1;
    MD_funct3   = f3;
    MD_rs1_data = a;
    MD_rs2_data = b;
    MD_rd_in    = rd;
    @(posedge SYS_clk); #1;
    MD_valid_in = 1'b0;
    MD_rs1_data = $urandom;
    MD_rs2_data = $urandom;
    MD_rd_in    = 5'($urandom);
    MD_funct3   = 3'($urandom);
  endtask

  // Edges counted from (and including) the accepting edge; bounded.
  task automatic wait_valid(output int n);
    n = 1;
    while (!MD_valid_out && n < 100) begin
      @(posedge SYS_clk); #1;
      n++;
    end
  endtask

  task automatic handshake(input string tag);
    MD_ready_in = 1'b1;
    @(posedge SYS_clk); #1;
    MD_ready_in = 1'b0;
    check({tag, "_rdy_after"}, {31'd0, MD_ready_out}, 32'd1);
    check({tag, "_vld_after"}, {31'd0, MD_valid_out}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int n;
    check({tag, "_rdy"}, {31'd0, MD_ready_out}, 32'd1);
    issue(f3, a, b, rd);
    wait_valid(n);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, MD_result, exp);
    check({tag, "_rd"}, {27'd0, MD_rd_out}, {27'd0, rd});
    handshake(tag);
  endtask

  initial begin
    int n;
    SYS_reset   = 1'b1;
    MD_valid_in = 1'b0;
    MD_ready_in = 1'b0;
    MD_funct3   = 3'd0;
    MD_rs1_data = 32'd0;
    MD_rs2_data = 32'd0;
    MD_rd_in    = 5'd0;
    repeat (3) @(posedge SYS_clk);
    #1;
    SYS_reset = 1'b0;

    check("rst_valid", {31'd0, MD_valid_out}, 32'd0);
    check("rst_ready", {31'd0, MD_ready_out}, 32'd1);
    check("rst_busy",  {31'd0, MD_busy}, 32'd0);
    check("rst_result", MD_result, 32'd0);
    check("rst_rd", {27'd0, MD_rd_out}, 32'd0);

    // Multiply family
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, MUL_LAT);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh_n", 3'b001, 32'hFFFF_FFFF, 32'd1,         5'd7, 32'hFFFF_FFFF, MUL_LAT);

    // Divide family
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8,  32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",   3'b101, 32'd100,       32'd7, 5'd10, 32'd14,        DIV_LAT);
    run_op("remu",   3'b111, 32'd100,       32'd7, 5'd11, 32'd2,         DIV_LAT);
    run_op("div_nb", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_nb", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1,         DIV_LAT);

    // Divide by zero and signed overflow
    run_op("div_z",  3'b100, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, SPC_LAT);
    run_op("divu_z", 3'b101, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, SPC_LAT);
    run_op("rem_z",  3'b110, 32'd5, 32'd0, 5'd16, 32'd5,         SPC_LAT);
    run_op("remu_z", 3'b111, 32'd5, 32'd0, 5'd17, 32'd5,         SPC_LAT);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, SPC_LAT);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         SPC_LAT);

    // Backpressure: result held, new request ignored while in DONE
    issue(3'b101, 32'd100, 32'd7, 5'd21);
    wait_valid(n);
    check("bp_lat", 32'(n), 32'(DIV_LAT));
    MD_valid_in = 1'b1;
    MD_funct3   = 3'b000;
    MD_rs1_data = 32'd3;
    MD_rs2_data = 32'd3;
    MD_rd_in    = 5'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_res", MD_result, 32'd14);
      check("bp_rd", {27'd0, MD_rd_out}, 32'd21);
      check("bp_rdy", {31'd0, MD_ready_out}, 32'd0);
      check("bp_vld", {31'd0, MD_valid_out}, 32'd1);
      @(posedge SYS_clk); #1;
    end
    MD_valid_in = 1'b0;
    handshake("bp");
    check("bp_busy", {31'd0, MD_busy}, 32'd0);

    // Reset during a divide
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd22);
    repeat (9) begin
      @(posedge SYS_clk); #1;
    end
    check("mid_busy", {31'd0, MD_busy}, 32'd1);
    SYS_reset = 1'b1;
    @(posedge SYS_clk); #1;
    SYS_reset = 1'b0;
    check("mid_vld",  {31'd0, MD_valid_out}, 32'd0);
    check("mid_busy0", {31'd0, MD_busy}, 32'd0);
    check("mid_rdy",  {31'd0, MD_ready_out}, 32'd1);
    run_op("mulhu_r", 3'b011, 32'd3, 32'd5, 5'd23, 32'd0, MUL_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit. It replaces the single-cycle combinational `*`, `/` and `%` operators in the datapath's R-type decode (opcode 0110011, funct7 0000001) with a multi-cycle engine. The engine uses a valid/ready handshake on both sides. XLEN is parametrised, and the unit implements full RISC-V divide-by-zero and signed-overflow semantics. The datapath stalls the PC while the unit holds MD_ready_out low.

Parameters:
XLEN, 32, operand/result width in bits (even, >= 8).
CNT_W, $clog2(XLEN)+1, width of the internal iteration counter.

Ports:
SYS_clk  input  1  clock, all state updates on rising edge.
SYS_reset  input  1  synchronous, active-high reset.
MD_valid_in  input  1  request valid.
MD_ready_out  output  1  unit can accept a request (high only in IDLE).
MD_funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
MD_rs1_data  input  XLEN  operand A.
MD_rs2_data  input  XLEN  operand B.
MD_rd_in  input  5  destination register tag.
MD_valid_out  output  1  result valid.
MD_ready_in  input  1  consumer accepts result.
MD_result  output  XLEN  result.
MD_rd_out  output  5  tag captured with the request.
MD_busy  output  1  high in CALC or DONE.

Behaviour:
- Reset values: state IDLE; MD_valid_out=0; MD_result=0; MD_rd_out=0; MD_busy=0; counter=0. MD_ready_out=1 in the cycle after reset.
- FSM states: IDLE, CALC, DONE. MD_ready_out = (state==IDLE). MD_valid_out = (state==DONE).
- IDLE:
  - On MD_valid_in && MD_ready_out, capture funct3, rd, and operand magnitudes.
  - Signedness: A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM.
  - Record the result sign: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - A special case goes directly to DONE; otherwise go to CALC with counter=0.
- Special cases, decided at accept:
  - Divide by zero (B==0): DIV/DIVU -> all ones; REM/REMU -> A unchanged.
  - Signed overflow (DIV/REM, A = 1<<(XLEN-1), B = all ones): DIV -> A; REM -> 0.
  - MD_valid_out rises 1 cycle after the accepting edge.
- CALC, multiply: radix-2 shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle. The partial remainder is XLEN+1 bits wide.
- CALC length: exactly XLEN cycles. On counter==XLEN-1, apply sign correction (two's complement of the 2*XLEN product or of the quotient/remainder where required) and go to DONE.
- Result selection: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
- Latency: for a normal op, MD_valid_out is first high XLEN+1 cycles after the accepting edge (33 for XLEN=32).
- DONE:
  - MD_result and MD_rd_out hold stable until MD_valid_out && MD_ready_in.
  - After that handshake, go to IDLE; no new accept happens in the same cycle.
- Inputs are ignored outside IDLE; MD_rs1_data and MD_rs2_data may change freely after accept.
- An invalid handshake cannot occur: funct3 is 3 bits, so every encoding is a legal op.
- Reset mid-operation (CALC or DONE): return to IDLE next edge; the pending result is discarded and MD_valid_out drops.
- Reset has priority over every handshake in the same cycle.

Optional Feature:
Macro MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops compute the full 2*XLEN signed/unsigned product in one cycle at accept and go straight to DONE, giving a latency of 1. Divide behaviour is unchanged.
- Undefined: multiply is iterative as above, with latency XLEN+1, and no `*` operator is inferred.

Test Plan:
- MUL A=7, B=0xFFFFFFFD (-3) -> MD_result=0xFFFFFFEB. MD_valid_out first high 33 cycles after accept (1 with MULDIV_FAST_MUL_EN). MD_rd_out equals the issued rd.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each has 33-cycle latency.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All four have 1-cycle latency.
- Backpressure: hold MD_ready_in=0 for 5 cycles in DONE -> MD_result and MD_rd_out stable and MD_ready_out=0 throughout. Assert MD_valid_in with new operands during DONE -> ignored. After the handshake, MD_ready_out=1 on the next cycle.
- Assert SYS_reset at cycle 10 of a DIV -> next cycle state IDLE, MD_valid_out=0, MD_busy=0. A following MULHU 3*5 -> 0.
